// File: rtl/pattern_if.sv
// Serial bus between the front end and the pattern detector.
// match_cnt exists only when PATTERN_MATCH_CNT_EN is defined.
interface pattern_if;
    logic        bit_stream;
    logic        found;
`ifdef PATTERN_MATCH_CNT_EN
    logic [15:0] match_cnt;

    modport master (output bit_stream, input found, input match_cnt);
    modport slave  (input bit_stream, output found, output match_cnt);
`else
    modport master (output bit_stream, input found);
    modport slave  (input bit_stream, output found);
`endif
endinterface

// File: rtl/pattern.sv
// Serial pattern detector: strobes found when the last PATT_W sampled bits equal PATTERN.
// Optional saturating match counter, enabled by defining PATTERN_MATCH_CNT_EN.
module pattern #(
    parameter int unsigned       PATT_W  = 4,
    parameter logic [PATT_W-1:0] PATTERN = 4'b1101
) (
    input  logic     clk,
    input  logic     rst_n,
    pattern_if.slave bus
);
    localparam int unsigned       FILL_W   = $clog2(PATT_W + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PATT_W);
    localparam logic [FILL_W-1:0] FILL_ARM = FILL_W'(PATT_W - 1);
    localparam logic [FILL_W-1:0] FILL_ONE = FILL_W'(1);

    generate
        if (PATT_W < 2 || PATT_W > 32) begin : g_bad_width
            $fatal(1, "pattern: PATT_W=%0d is outside 2..32", PATT_W);
        end
    endgenerate

    logic [PATT_W-1:0] shreg;
    logic [FILL_W-1:0] fill;
    logic [PATT_W-1:0] hist_next;
    logic              hit;

    // The fill gate keeps the zero-cleared history from matching an all-zero PATTERN.
    assign hist_next = {shreg[PATT_W-2:0], bus.bit_stream};
    assign hit       = (hist_next == PATTERN) && (fill >= FILL_ARM);

    // rst_n is active-high; the bit on a reset edge is discarded.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            shreg     <= '0;
            fill      <= '0;
            bus.found <= 1'b0;
        end else begin
            shreg <= hist_next;
            if (fill != FILL_MAX)
                fill <= fill + FILL_ONE;
            // An unknown compare falls into the else branch, so found stays 0.
            if (hit)
                bus.found <= 1'b1;
            else
                bus.found <= 1'b0;
        end
    end

`ifdef PATTERN_MATCH_CNT_EN
    always_ff @(posedge clk) begin
        if (rst_n)
            bus.match_cnt <= '0;
        else if (hit && (bus.match_cnt != 16'hFFFF))
            bus.match_cnt <= bus.match_cnt + 16'd1;
    end
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst_n)
            assert (!$isunknown(bus.bit_stream))
            else $error("pattern: bit_stream is X/Z at a sampling edge");
    end
`endif

endmodule

// File: tb/tb_pattern.sv
// Directed and model-checked bench for the serial pattern detector.
// Match counter checks are active when PATTERN_MATCH_CNT_EN is defined.
module tb_pattern;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    pattern_if bus  ();
    pattern_if bus0 ();

    pattern #(.PATT_W(4), .PATTERN(4'b1101)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    pattern #(.PATT_W(4), .PATTERN(4'b0000)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    logic q[$];
    int   m_hits;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Drive one bit (or a reset edge), then sample 1 ns after the rising edge.
    task automatic step(input logic b, input logic r);
        rst_n           = r;
        bus.bit_stream  = b;
        bus0.bit_stream = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Sequence bit i is bits[n-1-i]; exp/zexp give found of each DUT after that bit.
    task automatic drive_seq(input string tag, input int n, input logic [15:0] bits,
                             input logic [15:0] exp, input logic [15:0] zexp);
        for (int i = 0; i < n; i++) begin
            step(bits[n-1-i], 1'b0);
            chk($sformatf("%s.found[%0d]", tag, i + 1), 32'(bus.found), 32'(exp[n-1-i]));
            chk($sformatf("%s.zfound[%0d]", tag, i + 1), 32'(bus0.found), 32'(zexp[n-1-i]));
        end
    endtask

    initial begin
        rst_n           = 1'b1;
        bus.bit_stream  = 1'b0;
        bus0.bit_stream = 1'b0;

        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        chk("rst.found", 32'(bus.found), 32'd0);
        chk("rst.zfound", 32'(bus0.found), 32'd0);
`ifdef PATTERN_MATCH_CNT_EN
        chk("rst.cnt", 32'(bus.match_cnt), 32'd0);
`endif

        // 1101 then 1: single match; all-zero pattern arms after 4 bits and stays high.
        drive_seq("basic", 5, 16'b11011, 16'b00010, 16'b00011);

        // Overlap: 1101101 plus 101 gives three matches.
        step(1'b0, 1'b1);
        drive_seq("ovl", 10, 16'b1101101101, 16'b0001001001, 16'b0001111111);
`ifdef PATTERN_MATCH_CNT_EN
        chk("ovl.cnt", 32'(bus.match_cnt), 32'd3);
`endif
        step(1'b1, 1'b1);
        chk("rst2.found", 32'(bus.found), 32'd0);
        chk("rst2.zfound", 32'(bus0.found), 32'd0);
`ifdef PATTERN_MATCH_CNT_EN
        chk("rst2.cnt", 32'(bus.match_cnt), 32'd0);
`endif

        // Reset mid-pattern: the partial 110 is lost and the reset-edge bit discarded.
        drive_seq("mid", 3, 16'b110, 16'b000, 16'b000);
        step(1'b1, 1'b1);
        chk("mid.rst.found", 32'(bus.found), 32'd0);
        drive_seq("post", 4, 16'b1101, 16'b0001, 16'b0001);

        // Random stream against a bit-history model, with one reset in the middle.
        step(1'b0, 1'b1);
        q.delete();
        m_hits = 0;
        for (int i = 0; i < 1000; i++) begin
            logic b;
            logic r;
            logic e;
            b = 1'($urandom_range(0, 1));
            r = (i == 500);
            step(b, r);
            if (r) begin
                q.delete();
                m_hits = 0;
            end else begin
                q.push_back(b);
            end
            e = 1'b0;
            if (q.size() >= 4)
                e = q[q.size()-4] && q[q.size()-3] && !q[q.size()-2] && q[q.size()-1];
            if (e)
                m_hits++;
            chk($sformatf("rand.found[%0d]", i), 32'(bus.found), 32'(e));
        end
`ifdef PATTERN_MATCH_CNT_EN
        chk("rand.cnt", 32'(bus.match_cnt), 32'(m_hits));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
